// File: rtl/io_interp_phase_stepper.sv
// Purpose: walks the even/odd gray select pair of an N-phase interpolator one half-step at a time toward a target.
// Latency: first step on the edge after acceptance, then one step every settle+1 cycles; done one cycle after the last step/settle.
// Backpressure: target_ready is high only in IDLE; offers made while walking are ignored, and freeze holds the walk in place.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   target_valid/ready/phase    target handshake (position 0..2*NUM_PHASES-1)
//   settle_cycles, freeze       idle cycles after each step (sampled at accept), walk pause
//   mux_sel_a/b                 registered gray selects for the even/odd mux
//   phase_cur, step_pulse       current binary position, one-cycle pulse per move
//   busy, done                  walking indicator, one-cycle completion pulse
module io_interp_phase_stepper #(
  parameter int NUM_PHASES = 8,
  parameter int SEL_W      = $clog2(NUM_PHASES),
  parameter int PHASE_W    = SEL_W + 1,
  parameter int SETTLE_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target_valid,
  input  logic [PHASE_W-1:0]  target_phase,
  output logic                target_ready,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                freeze,
  output logic [SEL_W-1:0]    mux_sel_a,
  output logic [SEL_W-1:0]    mux_sel_b,
  output logic [PHASE_W-1:0]  phase_cur,
  output logic                step_pulse,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [PHASE_W-1:0]  HALF_RING = PHASE_W'(NUM_PHASES);
  localparam logic [PHASE_W-1:0]  ONE_POS   = PHASE_W'(1);
  localparam logic [SETTLE_W-1:0] ONE_CNT   = SETTLE_W'(1);

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W-1:0]  target_q, target_d;
  logic                dir_up_q, dir_up_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] count_q, count_d;
  logic [SEL_W-1:0]    sel_a_q, sel_a_d;
  logic [SEL_W-1:0]    sel_b_q, sel_b_d;
  logic                step_q, step_d;
  logic                done_q, done_d;

  logic [PHASE_W-1:0]  diff;
  logic [PHASE_W-1:0]  next_pos;
  logic [PHASE_W-1:0]  phase_d_plus1;
  logic [SEL_W-1:0]    sel_a_bin;
  logic [SEL_W-1:0]    sel_b_bin;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    settle_d = settle_q;
    count_d  = count_q;
    step_d   = 1'b0;
    done_d   = 1'b0;

    // Modular distance on the 2N ring; PHASE_W wrap does the mod for free.
    diff     = target_phase - phase_q;
    next_pos = dir_up_q ? (phase_q + ONE_POS) : (phase_q - ONE_POS);

    case (state_q)
      S_IDLE: begin
        if (target_valid) begin
          if (diff == '0) begin
            done_d = 1'b1;
          end else begin
            target_d = target_phase;
            // Half-way tie (diff == N) resolves upward.
            dir_up_d = (diff <= HALF_RING);
            settle_d = settle_cycles;
            state_d  = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (!freeze) begin
          phase_d = next_pos;
          step_d  = 1'b1;
          if (settle_q == '0) begin
            if (next_pos == target_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_SETTLE;
            count_d = settle_q;
          end
        end
      end
      S_SETTLE: begin
        if (!freeze) begin
          if (count_q <= ONE_CNT) begin
            count_d = '0;
            if (phase_q == target_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_STEP;
            end
          end else begin
            count_d = count_q - ONE_CNT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Selects are decoded from the next position so they land on the same
    // edge as phase_cur. Top PHASE_W-1 bits of (p+1) are already mod N.
    phase_d_plus1 = phase_d + ONE_POS;
    sel_a_bin     = phase_d_plus1[PHASE_W-1:1];
    sel_b_bin     = phase_d[PHASE_W-1:1];
    sel_a_d       = sel_a_bin ^ (sel_a_bin >> 1);
    sel_b_d       = sel_b_bin ^ (sel_b_bin >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      target_q <= '0;
      dir_up_q <= 1'b1;
      settle_q <= '0;
      count_q  <= '0;
      sel_a_q  <= '0;
      sel_b_q  <= '0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      dir_up_q <= dir_up_d;
      settle_q <= settle_d;
      count_q  <= count_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign target_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign mux_sel_a    = sel_a_q;
  assign mux_sel_b    = sel_b_q;
  assign phase_cur    = phase_q;
  assign step_pulse   = step_q;
  assign done         = done_q;

endmodule

// File: tb/tb_io_interp_phase_stepper.sv
module tb_io_interp_phase_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       frz;
  logic [3:0] settle;
  logic [4:0] tgt;
  logic [2:0] vld;
  logic [2:0] rdy, sp, bz, dn;

  logic [2:0] sa0, sb0; logic [3:0] pc0;   // N=8
  logic [3:0] sa1, sb1; logic [4:0] pc1;   // N=16
  logic [1:0] sa2, sb2; logic [2:0] pc2;   // N=4

  int errors = 0;
  int checks = 0;
  int cur [3];

  always #5 clk = ~clk;

  io_interp_phase_stepper #(.NUM_PHASES(8)) dut0 (
    .clk(clk), .reset(reset), .target_valid(vld[0]), .target_phase(tgt[3:0]),
    .target_ready(rdy[0]), .settle_cycles(settle), .freeze(frz),
    .mux_sel_a(sa0), .mux_sel_b(sb0), .phase_cur(pc0), .step_pulse(sp[0]),
    .busy(bz[0]), .done(dn[0]));

  io_interp_phase_stepper #(.NUM_PHASES(16)) dut1 (
    .clk(clk), .reset(reset), .target_valid(vld[1]), .target_phase(tgt[4:0]),
    .target_ready(rdy[1]), .settle_cycles(settle), .freeze(frz),
    .mux_sel_a(sa1), .mux_sel_b(sb1), .phase_cur(pc1), .step_pulse(sp[1]),
    .busy(bz[1]), .done(dn[1]));

  io_interp_phase_stepper #(.NUM_PHASES(4)) dut2 (
    .clk(clk), .reset(reset), .target_valid(vld[2]), .target_phase(tgt[2:0]),
    .target_ready(rdy[2]), .settle_cycles(settle), .freeze(frz),
    .mux_sel_a(sa2), .mux_sel_b(sb2), .phase_cur(pc2), .step_pulse(sp[2]),
    .busy(bz[2]), .done(dn[2]));

  function automatic int nph(input int i);
    return (i == 0) ? 8 : (i == 1) ? 16 : 4;
  endfunction

  function automatic logic [31:0] get_pc(input int i);
    return (i == 0) ? 32'(pc0) : (i == 1) ? 32'(pc1) : 32'(pc2);
  endfunction

  function automatic logic [31:0] get_sa(input int i);
    return (i == 0) ? 32'(sa0) : (i == 1) ? 32'(sa1) : 32'(sa2);
  endfunction

  function automatic logic [31:0] get_sb(input int i);
    return (i == 0) ? 32'(sb0) : (i == 1) ? 32'(sb1) : 32'(sb2);
  endfunction

  function automatic int md(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int i, input string tag, input int p,
                         input bit st, input bit bsy, input bit dne);
    int n;
    n = nph(i);
    chk({tag, " phase_cur"}, get_pc(i), 32'(p));
    chk({tag, " mux_sel_a"}, get_sa(i), 32'(gray(md((p + 1) / 2, n))));
    chk({tag, " mux_sel_b"}, get_sb(i), 32'(gray(md(p / 2, n))));
    chk({tag, " step_pulse"}, 32'(sp[i]), 32'(st));
    chk({tag, " busy"}, 32'(bz[i]), 32'(bsy));
    chk({tag, " done"}, 32'(dn[i]), 32'(dne));
    chk({tag, " target_ready"}, 32'(rdy[i]), 32'(!bsy));
  endtask

  // Walks DUT i from its current position to tg. The expected trajectory is
  // derived in "effective time" te (edges since acceptance, not counting
  // frozen edges): step k (1..n) lands at te = 1+(k-1)*(s+1), done at n*(s+1).
  task automatic walk(input int i, input int tg, input int s,
                      input int frz_at, input int frz_len, input int rst_at);
    int  n_ph, p, d, n, dir, total, te, fz, steps, exp_p, w;
    bit  frozen, exp_st;
    logic [31:0] pa, pb;
    n_ph  = nph(i);
    p     = cur[i];
    d     = md(tg - p, 2 * n_ph);
    n     = (d <= n_ph) ? d : 2 * n_ph - d;
    dir   = (d <= n_ph) ? 1 : -1;
    total = n * (s + 1);
    te    = 0;
    fz    = 0;
    frozen = 1'b0;

    for (w = 0; w < 60 && rdy[i] !== 1'b1; w++) begin
      @(posedge clk); #1;
    end
    if (w == 60) chk("ready_timeout", 32'(rdy[i]), 32'd1);

    tgt    = 5'(tg);
    settle = 4'(s);
    vld[i] = 1'b1;
    @(posedge clk); #1;
    vld[i] = 1'b0;

    forever begin
      steps  = (te == 0) ? 0 : (((te - 1) / (s + 1) + 1 < n) ? (te - 1) / (s + 1) + 1 : n);
      exp_p  = md(p + dir * steps, 2 * n_ph);
      exp_st = !frozen && te >= 1 && ((te - 1) % (s + 1) == 0) && ((te - 1) / (s + 1) < n);
      chk_all(i, "walk", exp_p, exp_st, te < total, !frozen && te == total);
      if (exp_st)
        chk("one_gray_bit", 32'($countones(pa ^ get_sa(i)) + $countones(pb ^ get_sb(i))), 32'd1);
      pa = get_sa(i);
      pb = get_sb(i);

      if (te == rst_at && !frozen) begin
        vld    = '0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_all(i, "mid_reset", 0, 1'b0, 1'b0, 1'b0);
        cur = '{0, 0, 0};
        frz = 1'b0;
        return;
      end
      if (te == total) break;

      frozen = (te == frz_at && fz < frz_len);
      if (frozen) fz++;
      frz = frozen;
      // A competing offer held during the walk must be ignored.
      tgt    = 5'($urandom_range(0, 31));
      vld[i] = 1'b1;
      @(posedge clk); #1;
      if (!frozen) te++;
    end
    vld[i] = 1'b0;
    frz    = 1'b0;
    cur[i] = tg;
  endtask

  initial begin
    int i, tg, s, fa, fl;
    reset  = 1'b1;
    frz    = 1'b0;
    settle = '0;
    tgt    = '0;
    vld    = '0;
    cur    = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_all(k, "reset", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // N=8 directed sequence
    walk(0, 5, 0, 1000, 0, -1);        // 1..5 on consecutive cycles
    walk(0, 14, 0, 1000, 0, -1);       // d=9 -> down
    walk(0, 2, 0, 1000, 0, -1);        // d=4 -> up through 15,0,1,2
    walk(0, 0, 1, 1000, 0, -1);
    walk(0, 8, 3, 1000, 0, -1);        // tie d=8 -> up, done at 32
    walk(0, 3, 2, 5, 10, -1);          // 10-cycle freeze mid-walk
    walk(0, 3, 2, 1000, 0, -1);        // d==0: done next cycle, no step
    walk(0, 0, 0, 1000, 0, -1);
    walk(0, 7, 0, 1000, 0, 6);         // reset at position 6

    // N=16 and N=4 mid-walk resets
    walk(1, 9, 0, 1000, 0, -1);
    walk(1, 0, 0, 1000, 0, -1);
    walk(1, 12, 1, 1000, 0, 6);
    walk(2, 6, 0, 1000, 0, -1);        // d=6 > 4 -> down 7,6
    walk(2, 3, 0, 1000, 0, -1);
    walk(2, 2, 0, 1000, 0, 1);

    // Randomized walks across all three sizes
    for (int r = 0; r < 24; r++) begin
      i  = $urandom_range(0, 2);
      tg = $urandom_range(0, 2 * nph(i) - 1);
      s  = $urandom_range(0, 3);
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 1000;
      fl = $urandom_range(1, 5);
      walk(i, tg, s, fa, fl, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
